// File: rtl/fc_mac_layer.sv
// ---------------------------------------------------------------------------
// fc_mac_layer
//   Fully-connected layer datapath. Input activations arrive one word per
//   accepted cycle. Each word is multiplied by LAYER_HEIGHT weights in
//   parallel, one weight per neuron, and the products are accumulated at full
//   precision. After INPUT_SIZE accepts, every neuron adds its bias. The sum
//   is then rescaled by FRAC_BITS and saturated to WORD_SIZE bits. The
//   finished vector is held on a valid/ready output until downstream takes
//   it. There is no ReLU stage.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   reset_n_i      asynchronous active-low reset
//   valid_i        data_i holds an input word
//   ready_o        block accepts data_i this cycle (state == eACCUM)
//   data_i         signed input activation
//   weight_addr_o  index of the current input word, addresses the weight ROM
//   weights_i      weights for all neurons at weight_addr_o; neuron j at word j
//   bias_i         per-neuron signed bias, held static
//   valid_o        data_o holds a finished vector (state == eDONE)
//   ready_i        downstream takes data_o this cycle
//   data_o         signed result vector; word j belongs to neuron j
// ---------------------------------------------------------------------------
module fc_mac_layer #(
    parameter int INPUT_SIZE   = 8,
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16,
    parameter int FRAC_BITS    = 8,
    localparam int CNT_W       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [WORD_SIZE-1:0]               data_i,
    output logic [CNT_W-1:0]                   weight_addr_o,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0]  weights_i,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0]  bias_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [LAYER_HEIGHT*WORD_SIZE-1:0]  data_o
);

    localparam int PROD_W = 2 * WORD_SIZE;
    // Enough headroom for INPUT_SIZE worst-case products, so the sum never wraps.
    localparam int ACC_W  = 2 * WORD_SIZE + $clog2(INPUT_SIZE + 1) + 1;
    // One extra bit so that adding the shifted bias cannot overflow either.
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - WORD_SIZE + 1){1'b0}}, {(WORD_SIZE - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - WORD_SIZE + 1){1'b1}}, {(WORD_SIZE - 1){1'b0}}};
    localparam logic [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE - 1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE - 1){1'b0}}};

    typedef enum logic {
        eACCUM = 1'b0,
        eDONE  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             accept;
    logic             handoff;
    logic             last_word;

    // Handshake outputs come straight from the state register, so they are
    // never X once reset has been applied.
    assign ready_o       = (state_reg == eACCUM);
    assign valid_o       = (state_reg == eDONE);
    assign weight_addr_o = count_reg;

    assign accept    = valid_i && ready_o;
    assign handoff   = valid_o && ready_i;
    assign last_word = (count_reg == CNT_W'(INPUT_SIZE - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= eACCUM;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            eACCUM: begin
                if (accept) begin
                    if (last_word) begin
                        state_next = eDONE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            eDONE: begin
                if (ready_i) begin
                    state_next = eACCUM;
                end
            end
            default: begin
                state_next = eACCUM;
                count_next = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LAYER_HEIGHT; gi++) begin : gen_neuron
            logic signed [WORD_SIZE-1:0] weight_word;
            logic signed [WORD_SIZE-1:0] bias_word;
            logic signed [PROD_W-1:0]    data_ext;
            logic signed [PROD_W-1:0]    weight_ext;
            logic signed [PROD_W-1:0]    prod;
            logic signed [ACC_W-1:0]     acc_reg;
            logic signed [SUM_W-1:0]     bias_shift;
            logic signed [SUM_W-1:0]     sum;
            logic signed [SUM_W-1:0]     res;

            assign weight_word = weights_i[gi*WORD_SIZE +: WORD_SIZE];
            assign bias_word   = bias_i[gi*WORD_SIZE +: WORD_SIZE];

            // Sign-extend both operands to the product width so that the
            // multiply is full-precision signed.
            assign data_ext   = {{(PROD_W - WORD_SIZE){data_i[WORD_SIZE-1]}}, data_i};
            assign weight_ext = {{(PROD_W - WORD_SIZE){weight_word[WORD_SIZE-1]}}, weight_word};
            assign prod       = data_ext * weight_ext;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    acc_reg <= '0;
                end else if (handoff) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= acc_reg + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                end
            end

            // The bias is in the word Q format while the accumulator carries
            // 2*FRAC_BITS fraction bits, so align the bias before adding.
            assign bias_shift = {{(SUM_W - WORD_SIZE - FRAC_BITS){bias_word[WORD_SIZE-1]}},
                                 bias_word, {FRAC_BITS{1'b0}}};
            assign sum = {acc_reg[ACC_W-1], acc_reg} + bias_shift;
            // The arithmetic shift truncates toward minus infinity.
            assign res = sum >>> FRAC_BITS;

            assign data_o[gi*WORD_SIZE +: WORD_SIZE] =
                (res > SAT_MAX) ? WORD_MAX :
                (res < SAT_MIN) ? WORD_MIN :
                                  res[WORD_SIZE-1:0];
        end
    endgenerate

endmodule
